// File: rtl/qdec_mvd_dec.sv
// qdec_mvd_dec: CABAC motion-vector-difference decoder sub-FSM (gt0/gt1 flags, EGk remainder, sign).
// Define QDEC_MVD_PREFIX_CHK_EN to abort with mvd_err_intr when the EGk prefix exceeds MAX_PREFIX.
module qdec_mvd_dec #(
    parameter int NUM_COMP     = 2,
    parameter int EG_K         = 1,
    parameter int MAX_PREFIX   = 16,
    parameter int MVD_W        = 16,
    parameter int CTX_ADDR_W   = 10,
    parameter int CTX_GT0_BASE = 0,
    parameter int CTX_GT1_BASE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mvd_start,
    input  logic                      mvd_zero,
    input  logic [1:0]                slice_type,
    input  logic                      cabac_init_flag,
    output logic [CTX_ADDR_W-1:0]     ctx_mvd_addr,
    output logic                      ctx_mvd_addr_vld,
    output logic                      dec_run_mvd,
    output logic                      EPMode_mvd,
    input  logic                      dec_rdy,
    input  logic                      ruiBin,
    input  logic                      ruiBin_vld,
    output logic [NUM_COMP*MVD_W-1:0] mvd_out,
    output logic                      mvd_out_vld,
    output logic                      mvd_done_intr,
    output logic                      mvd_err_intr
);
    localparam int ACC_W = MAX_PREFIX + EG_K + 1;
    localparam int CW    = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;
    localparam int KW    = 8;
    localparam logic [CW-1:0]    LAST    = CW'(NUM_COMP - 1);
    localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);

    typedef enum logic [2:0] {IDLE, GT0, GT1, EG_PRE, EG_SUF, SIGN, DONE, ABORT} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               comp, comp_nxt;
    logic [NUM_COMP-1:0]         gt0, gt1, gt0_new, gt1_new;
    logic [CW:0]                 nx_sel, first_sel;
    logic [ACC_W-1:0]            acc;
    logic [KW-1:0]               k, suf_left;
    logic                        init_off, outstanding, need_bin, bin_ok, pre_ovf;
    logic [NUM_COMP*MVD_W-1:0]   mvd_work;
    logic [MVD_W-1:0]            abs_val, mvd_val;

    // Returns {found, index} of the lowest set mask bit at or above lo.
    function automatic logic [CW:0] first_set_from(input logic [NUM_COMP-1:0] mask, input int lo);
        logic [CW:0] r;
        r = '0;
        for (int i = NUM_COMP - 1; i >= 0; i--) begin
            if (mask[i] && (i >= lo)) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    assign bin_ok           = ruiBin_vld && outstanding;
    assign ctx_mvd_addr_vld = need_bin && !outstanding && dec_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            comp  <= '0;
        end else begin
            state <= state_nxt;
            comp  <= comp_nxt;
        end
    end

    // Components with no bins left are skipped by jumping straight to the next flagged index.
    always_comb begin
        state_nxt    = state;
        comp_nxt     = comp;
        gt0_new      = gt0;
        gt1_new      = gt1;
        need_bin     = 1'b0;
        EPMode_mvd   = 1'b0;
        ctx_mvd_addr = '0;
        if (state == GT0) gt0_new[comp] = ruiBin;
        if (state == GT1) gt1_new[comp] = ruiBin;
        nx_sel    = first_set_from(gt0_new, int'(comp) + 1);
        first_sel = first_set_from(gt0_new, 0);
        abs_val   = MVD_W'(acc) + MVD_W'(gt0[comp]) + MVD_W'(gt1[comp]);
        mvd_val   = ruiBin ? -abs_val : abs_val;
        case (state)
            IDLE: begin
                comp_nxt = '0;
                if (mvd_start) state_nxt = mvd_zero ? DONE : GT0;
            end
            GT0: begin
                need_bin     = 1'b1;
                ctx_mvd_addr = CTX_ADDR_W'(CTX_GT0_BASE) + CTX_ADDR_W'(init_off);
                if (bin_ok) begin
                    if (comp != LAST) begin
                        comp_nxt = comp + CW'(1);
                    end else if (first_sel[CW]) begin
                        state_nxt = GT1;
                        comp_nxt  = first_sel[CW-1:0];
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            GT1: begin
                need_bin     = 1'b1;
                ctx_mvd_addr = CTX_ADDR_W'(CTX_GT1_BASE) + CTX_ADDR_W'(init_off);
                if (bin_ok) begin
                    if (nx_sel[CW]) begin
                        comp_nxt = nx_sel[CW-1:0];
                    end else begin
                        comp_nxt  = first_sel[CW-1:0];
                        state_nxt = gt1_new[first_sel[CW-1:0]] ? EG_PRE : SIGN;
                    end
                end
            end
            EG_PRE: begin
                need_bin   = 1'b1;
                EPMode_mvd = 1'b1;
                if (bin_ok) begin
                    if (pre_ovf)      state_nxt = ABORT;
                    else if (!ruiBin) state_nxt = (k == KW'(0)) ? SIGN : EG_SUF;
                end
            end
            EG_SUF: begin
                need_bin   = 1'b1;
                EPMode_mvd = 1'b1;
                if (bin_ok && (suf_left == KW'(1))) state_nxt = SIGN;
            end
            SIGN: begin
                need_bin   = 1'b1;
                EPMode_mvd = 1'b1;
                if (bin_ok) begin
                    if (nx_sel[CW]) begin
                        comp_nxt  = nx_sel[CW-1:0];
                        state_nxt = gt1[nx_sel[CW-1:0]] ? EG_PRE : SIGN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding   <= 1'b0;
            dec_run_mvd   <= 1'b0;
            init_off      <= 1'b0;
            gt0           <= '0;
            gt1           <= '0;
            acc           <= '0;
            k             <= '0;
            suf_left      <= '0;
            mvd_work      <= '0;
            mvd_out       <= '0;
            mvd_out_vld   <= 1'b0;
            mvd_done_intr <= 1'b0;
        end else begin
            dec_run_mvd   <= ctx_mvd_addr_vld;
            mvd_out_vld   <= (state == DONE);
            mvd_done_intr <= (state == DONE);
            if (ruiBin_vld)       outstanding <= 1'b0;
            if (ctx_mvd_addr_vld) outstanding <= 1'b1;
            case (state)
                IDLE: if (mvd_start) begin
                    // init_type-1: P (and I) select offset 1 only with cabac_init_flag, B the other way round.
                    init_off <= ((slice_type == 2'd1) || (slice_type == 2'd2)) ? cabac_init_flag : !cabac_init_flag;
                    gt0      <= '0;
                    gt1      <= '0;
                    acc      <= '0;
                    k        <= KW'(EG_K);
                    mvd_work <= '0;
                end
                GT0: if (bin_ok) gt0 <= gt0_new;
                GT1: if (bin_ok) gt1 <= gt1_new;
                EG_PRE: if (bin_ok && !pre_ovf) begin
                    if (ruiBin) begin
                        acc <= acc + (ACC_ONE << k);
                        k   <= k + KW'(1);
                    end else begin
                        suf_left <= k;
                    end
                end
                EG_SUF: if (bin_ok) begin
                    acc      <= acc + (ACC_W'(ruiBin) << (suf_left - KW'(1)));
                    suf_left <= suf_left - KW'(1);
                end
                SIGN: if (bin_ok) begin
                    mvd_work[comp*MVD_W +: MVD_W] <= mvd_val;
                    acc <= '0;
                    k   <= KW'(EG_K);
                end
                DONE:    mvd_out <= mvd_work;
                ABORT:   mvd_out <= '0;
                default: ;
            endcase
        end
    end

`ifdef QDEC_MVD_PREFIX_CHK_EN
    localparam int PW = $clog2(MAX_PREFIX + 1);
    logic [PW-1:0] pre_cnt;

    assign pre_ovf = (pre_cnt == PW'(MAX_PREFIX)) && ruiBin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            mvd_err_intr <= 1'b0;
        end else begin
            mvd_err_intr <= (state == ABORT);
            if ((state == IDLE) || (state == SIGN))       pre_cnt <= '0;
            else if ((state == EG_PRE) && bin_ok && ruiBin) pre_cnt <= pre_cnt + PW'(1);
        end
    end
`else
    assign pre_ovf      = 1'b0;
    assign mvd_err_intr = 1'b0;
`endif

endmodule

// File: tb/tb_qdec_mvd_dec.sv
// tb_qdec_mvd_dec: randomized bench; an MVD encoder model turns chosen MVD values into the
// expected bin requests (address, bypass mode) and the expected decoded result.
module tb_qdec_mvd_dec;
    localparam int NUM_COMP = 2, EG_K = 1, MAX_PREFIX = 16, MVD_W = 16, CTX_ADDR_W = 10;
    localparam int GT0_BASE = 0, GT1_BASE = 2;
    localparam int KIND_GT = 0, KIND_PRE = 1, KIND_SUF = 2, KIND_SIGN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mvd_start = 1'b0, mvd_zero = 1'b0, cabac_init_flag = 1'b0;
    logic [1:0] slice_type = 2'd0;
    logic dec_rdy = 1'b0, ruiBin = 1'b0, ruiBin_vld = 1'b0;
    logic [CTX_ADDR_W-1:0] ctx_mvd_addr;
    logic ctx_mvd_addr_vld, dec_run_mvd, EPMode_mvd;
    logic [NUM_COMP*MVD_W-1:0] mvd_out;
    logic mvd_out_vld, mvd_done_intr, mvd_err_intr;

    always #5 clk = ~clk;

    qdec_mvd_dec #(
        .NUM_COMP(NUM_COMP), .EG_K(EG_K), .MAX_PREFIX(MAX_PREFIX), .MVD_W(MVD_W),
        .CTX_ADDR_W(CTX_ADDR_W), .CTX_GT0_BASE(GT0_BASE), .CTX_GT1_BASE(GT1_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mvd_start(mvd_start), .mvd_zero(mvd_zero),
        .slice_type(slice_type), .cabac_init_flag(cabac_init_flag),
        .ctx_mvd_addr(ctx_mvd_addr), .ctx_mvd_addr_vld(ctx_mvd_addr_vld),
        .dec_run_mvd(dec_run_mvd), .EPMode_mvd(EPMode_mvd), .dec_rdy(dec_rdy),
        .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld), .mvd_out(mvd_out),
        .mvd_out_vld(mvd_out_vld), .mvd_done_intr(mvd_done_intr), .mvd_err_intr(mvd_err_intr)
    );

    int testsRun = 0;
    int testsFailed = 0;
    bit binQ[$];
    bit epQ[$];
    int addrQ[$];
    int kindQ[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pushBin(input bit b, input bit ep, input int addr, input int kind);
        binQ.push_back(b);
        epQ.push_back(ep);
        addrQ.push_back(addr);
        kindQ.push_back(kind);
    endtask

    // Encoder view: which bins an HEVC-style encoder emits for the given MVD pair.
    task automatic buildModel(input int v0, input int v1, input logic [1:0] st, input logic cf);
        int v[2];
        int initType, a, rem, k;
        bit isP;
        v[0] = v0;
        v[1] = v1;
        isP = (st == 2'd1) || (st == 2'd2);
        initType = isP ? (cf ? 2 : 1) : (cf ? 1 : 2);
        for (int c = 0; c < 2; c++) pushBin(v[c] != 0, 1'b0, GT0_BASE + initType - 1, KIND_GT);
        for (int c = 0; c < 2; c++) begin
            a = (v[c] < 0) ? -v[c] : v[c];
            if (a != 0) pushBin(a > 1, 1'b0, GT1_BASE + initType - 1, KIND_GT);
        end
        for (int c = 0; c < 2; c++) begin
            a = (v[c] < 0) ? -v[c] : v[c];
            if (a >= 2) begin
                rem = a - 2;
                k = EG_K;
                while (rem >= (1 << k)) begin
                    pushBin(1'b1, 1'b1, 0, KIND_PRE);
                    rem -= (1 << k);
                    k++;
                end
                pushBin(1'b0, 1'b1, 0, KIND_PRE);
                for (int i = k - 1; i >= 0; i--) pushBin(((rem >> i) & 1) != 0, 1'b1, 0, KIND_SUF);
            end
            if (a != 0) pushBin(v[c] < 0, 1'b1, 0, KIND_SIGN);
        end
    endtask

    function automatic int randMvd();
        int mag;
        case ($urandom_range(0, 3))
            0: return 0;
            1: mag = 1;
            2: mag = int'($urandom_range(2, 40));
            default: mag = int'($urandom_range(41, 30000));
        endcase
        return ($urandom_range(0, 1) != 0) ? -mag : mag;
    endfunction

    // mode: 0 plain, 1 stall mid-prefix, 2 reset during suffix, 3 stray bin at start, 4 prefix overflow
    task automatic applyStimulus(input int v0, input int v1, input logic [1:0] st, input logic cf,
                                 input logic zero, input int mode);
        int cyc = 0, lat = 0, lastBinCyc = 0, stallLeft = 0, kind = 0;
        bit pending = 0, pendBin = 0, pendEp = 0, prevVld = 0, finished = 0, resetNext = 0, stallUsed = 0;
        logic [31:0] expMvd;
        binQ.delete(); epQ.delete(); addrQ.delete(); kindQ.delete();
        if (mode == 4) begin
            pushBin(1'b1, 1'b0, GT0_BASE, KIND_GT);
            pushBin(1'b0, 1'b0, GT0_BASE, KIND_GT);
            pushBin(1'b1, 1'b0, GT1_BASE, KIND_GT);
            for (int i = 0; i < MAX_PREFIX + 1; i++) pushBin(1'b1, 1'b1, 0, KIND_PRE);
        end else if (!zero) begin
            buildModel(v0, v1, st, cf);
        end
        expMvd = zero ? 32'd0 : {v1[15:0], v0[15:0]};
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            mvd_start = (cyc == 0);
            mvd_zero = zero;
            slice_type = st;
            cabac_init_flag = cf;
            ruiBin_vld = 1'b0;
            ruiBin = 1'($urandom_range(0, 1));
            if (resetNext) begin
                rst_n = 1'b0;
                dec_rdy = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                checkOutput("rst_addr_vld", ctx_mvd_addr_vld, 0);
                checkOutput("rst_dec_run", dec_run_mvd, 0);
                checkOutput("rst_epmode", EPMode_mvd, 0);
                checkOutput("rst_addr", ctx_mvd_addr, 0);
                checkOutput("rst_mvd_out", mvd_out, 0);
                checkOutput("rst_out_vld", mvd_out_vld, 0);
                checkOutput("rst_done", mvd_done_intr, 0);
                @(negedge clk);
                ruiBin_vld = 1'b1;
                ruiBin = pendBin;
                #1;
                checkOutput("late_bin_no_req", ctx_mvd_addr_vld, 0);
                @(negedge clk);
                ruiBin_vld = 1'b0;
                #1;
                checkOutput("late_bin_no_done", mvd_out_vld | mvd_done_intr, 0);
                return;
            end
            if (pending) begin
                if (lat == 0) begin
                    ruiBin_vld = 1'b1;
                    ruiBin = pendBin;
                    pending = 0;
                    lastBinCyc = cyc;
                end else begin
                    lat--;
                end
            end
            dec_rdy = ($urandom_range(0, 3) != 0);
            if (stallLeft > 0) begin
                dec_rdy = 1'b0;
                stallLeft--;
            end
            if (mode == 3 && cyc >= 1 && cyc <= 3) begin
                dec_rdy = 1'b0;
                if (cyc == 2) begin
                    ruiBin_vld = 1'b1;
                    ruiBin = 1'b1;
                end
            end
            #1;
            if (cyc == 0) checkOutput("no_req_in_idle", ctx_mvd_addr_vld, 0);
            if (!dec_rdy) checkOutput("no_req_when_busy", ctx_mvd_addr_vld, 0);
            checkOutput("dec_run_delay", dec_run_mvd, prevVld);
            prevVld = ctx_mvd_addr_vld;
            if (pending) checkOutput("ep_hold", EPMode_mvd, pendEp);
            if (ctx_mvd_addr_vld) begin
                checkOutput("single_outstanding", pending, 0);
                if (binQ.size() == 0) begin
                    checkOutput("extra_request", 1, 0);
                end else begin
                    checkOutput("req_addr", ctx_mvd_addr, addrQ[0]);
                    checkOutput("req_ep", EPMode_mvd, epQ[0]);
                    pendBin = binQ.pop_front();
                    pendEp = epQ.pop_front();
                    void'(addrQ.pop_front());
                    kind = kindQ.pop_front();
                    pending = 1;
                    lat = int'($urandom_range(0, 2));
                    if (mode == 1 && kind == KIND_PRE && !stallUsed) begin
                        stallUsed = 1;
                        stallLeft = 10;
                    end
                    if (mode == 2 && kind == KIND_SUF) resetNext = 1;
                end
            end
            if (mvd_out_vld || mvd_done_intr || mvd_err_intr) begin
                finished = 1;
                if (mode == 4) begin
                    checkOutput("err_pulse", mvd_err_intr, 1);
                    checkOutput("no_done_on_err", mvd_done_intr, 0);
                    checkOutput("no_vld_on_err", mvd_out_vld, 0);
                    checkOutput("err_mvd_zero", mvd_out, 0);
                end else begin
                    checkOutput("done_pulse", mvd_done_intr, 1);
                    checkOutput("out_vld_pulse", mvd_out_vld, 1);
                    checkOutput("no_err", mvd_err_intr, 0);
                    checkOutput("mvd_value", mvd_out, expMvd);
                end
                checkOutput("done_latency", cyc, lastBinCyc + 2);
                checkOutput("bins_consumed", binQ.size(), 0);
                checkOutput("bin_not_pending", pending, 0);
            end
            cyc++;
        end
        if (!finished) begin
            checkOutput("timeout", 0, 1);
        end else begin
            @(negedge clk);
            mvd_start = 1'b0;
            ruiBin_vld = 1'b0;
            #1;
            checkOutput("pulse_width", {mvd_out_vld, mvd_done_intr, mvd_err_intr}, 0);
            if (mode != 4) checkOutput("mvd_held", mvd_out, expMvd);
        end
        mvd_start = 1'b0;
        ruiBin_vld = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_addr_vld", ctx_mvd_addr_vld, 0);
        checkOutput("reset_dec_run", dec_run_mvd, 0);
        checkOutput("reset_epmode", EPMode_mvd, 0);
        checkOutput("reset_mvd_out", mvd_out, 0);
        checkOutput("reset_out_vld", mvd_out_vld, 0);
        checkOutput("reset_done", mvd_done_intr, 0);
        checkOutput("reset_err", mvd_err_intr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 0, 2'd1, 1'b0, 1'b0, 0);
        applyStimulus(1, -1, 2'd0, 1'b0, 1'b0, 0);
        applyStimulus(5, 0, 2'd1, 1'b0, 1'b0, 0);
        applyStimulus(0, 0, 2'd1, 1'b0, 1'b1, 0);
        applyStimulus(5, 0, 2'd1, 1'b0, 1'b0, 1);
        applyStimulus(5, -37, 2'd1, 1'b1, 1'b0, 2);
        applyStimulus(3, -2, 2'd2, 1'b1, 1'b0, 3);
`ifdef QDEC_MVD_PREFIX_CHK_EN
        applyStimulus(0, 0, 2'd1, 1'b0, 1'b0, 4);
        applyStimulus(-9, 12, 2'd0, 1'b1, 1'b0, 0);
`endif
        for (int r = 0; r < 40; r++) begin
            int m;
            m = int'($urandom_range(0, 3));
            if (m == 2) m = 0;
            applyStimulus(randMvd(), randMvd(), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), m);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/qdec_mvd_dec.md
# qdec_mvd_dec

Parametrised CABAC motion-vector-difference decoder sub-FSM for the inter prediction-unit path. Handles NUM_COMP components: greater0/greater1 context-coded flags, EGk bypass remainder and bypass sign. Issues one bin request at a time to the shared arithmetic decoder and returns signed MVD values with a done interrupt. It replaces the fixed two-component, fixed-EG1, flags-only MVD FSM, and adds value reconstruction, back-pressure, a zero-MVD shortcut and init-type context offsets.

## Interface
- NUM_COMP, 2: MVD components decoded per start, with indexes 0..NUM_COMP-1 (x, y, ...).
- EG_K, 1: initial Exp-Golomb order for the abs_mvd_minus2 remainder.
- MAX_PREFIX, 16: maximum EGk prefix length (count of 1-bins).
- MVD_W, 16: signed output width per component.
- CTX_ADDR_W, 10: context address width.
- CTX_GT0_BASE, 0: context address of abs_mvd_greater0_flag, init-type 1.
- CTX_GT1_BASE, 2: context address of abs_mvd_greater1_flag, init-type 1.
- Ports:
  - clk  in  1  clock.
  - rst_n  in  1  reset, synchronous, active-low.
  - mvd_start  in  1  start pulse; ignored unless state is IDLE.
  - mvd_zero  in  1  sampled with mvd_start; 1 means decode no bins and output all-zero MVD.
  - slice_type  in  2  0=B, 1=P, 2=I; sampled at start.
  - cabac_init_flag  in  1  sampled at start.
  - ctx_mvd_addr  out  CTX_ADDR_W  context address; valid with ctx_mvd_addr_vld.
  - ctx_mvd_addr_vld  out  1  one-cycle bin request.
  - dec_run_mvd  out  1  ctx_mvd_addr_vld delayed by 1 cycle.
  - EPMode_mvd  out  1  bypass bin when 1; valid with ctx_mvd_addr_vld and held until ruiBin_vld.
  - dec_rdy  in  1  decoder can accept a request.
  - ruiBin  in  1  decoded bin.
  - ruiBin_vld  in  1  bin valid.
  - mvd_out  out  NUM_COMP*MVD_W  signed MVDs, with component c at bits [c*MVD_W +: MVD_W].
  - mvd_out_vld  out  1  one-cycle pulse; mvd_out is stable from this pulse until the next start.
  - mvd_done_intr  out  1  one-cycle pulse, coincident with mvd_out_vld.
  - mvd_err_intr  out  1  prefix overflow pulse (see Configuration).

## Operation
- States and transitions:
  - IDLE: on mvd_start, go to DONE if mvd_zero=1, otherwise go to GT0.
  - GT0: decode one flag per component c=0..N-1.
  - GT1: decode one flag for each c with gt0[c]=1.
  - Per component c, in ascending order: EG_PRE then EG_SUF, only if gt1[c]=1; then SIGN, only if gt0[c]=1.
  - DONE: go to IDLE after one cycle.
- If every gt0 is 0, go straight from GT0 to DONE. Components that need no bins are skipped with zero extra cycles.
- Context address: init_type = (slice_type==P) ? (cabac_init_flag ? 2 : 1) : (cabac_init_flag ? 1 : 2).
  - GT0 requests use addr = CTX_GT0_BASE + init_type - 1, with EPMode=0.
  - GT1 requests use addr = CTX_GT1_BASE + init_type - 1, with EPMode=0.
  - EG and SIGN requests use addr = 0, with EPMode=1.
  - slice_type=I with mvd_zero=0 is treated as P.
- Request rule:
  - At most one outstanding bin.
  - A request is issued in a cycle where state needs a bin, no request is outstanding, and dec_rdy=1.
  - The outstanding flag clears on ruiBin_vld.
  - ruiBin_vld with no request outstanding is ignored.
- EGk decode: k starts at EG_K and acc starts at 0.
  - Each prefix 1-bin: acc += 1<<k, then k++.
  - A prefix 0-bin ends the prefix. Then k suffix bins are read MSB-first and added to acc.
  - When k=0 at that point, go straight to SIGN.
- Value: abs = gt0 + gt1 + acc; mvd = sign ? -abs : abs. The result is truncated to MVD_W bits (two's complement wrap).
- Internal acc width is MAX_PREFIX+EG_K+1.
- Reset mid-operation:
  - Return to IDLE and drop the outstanding request.
  - A late ruiBin_vld is then ignored.
  - Reset values of all outputs and mvd_out are 0.

## Timing
- ctx_mvd_addr_vld can first rise 1 cycle after mvd_start is sampled. The next request can be issued 1 cycle after the ruiBin_vld of the previous bin.
- dec_rdy=0 stalls request issue indefinitely; the state is held.
- mvd_out_vld and mvd_done_intr pulse 2 cycles after the last ruiBin_vld, or 2 cycles after mvd_start when mvd_zero=1.
- mvd_start asserted in the same cycle as the DONE state is ignored.

## Configuration
- QDEC_MVD_PREFIX_CHK_EN defined:
  - A prefix 1-bin that would make the prefix length MAX_PREFIX+1 aborts the decode.
  - mvd_err_intr pulses for 1 cycle, 2 cycles after that bin.
  - mvd_out is set to 0. No mvd_out_vld or mvd_done_intr is produced.
  - The block returns to IDLE.
- QDEC_MVD_PREFIX_CHK_EN undefined: no check is made. mvd_err_intr is tied 0. The prefix continues and acc wraps modulo its width.

## Test plan
- Default parameters, P slice, init flag 0, bins GT0=0,0 -> exactly 2 context requests, both at addr CTX_GT0_BASE; mvd_out=(0,0); pulse 2 cycles after 2nd bin.
- B slice, init flag 0, bins 1,1 | 0,0 | sign 0 | sign 1 -> GT1 addr=CTX_GT1_BASE+1; mvd=(+1,-1).
- Bins gt0=1,0; gt1=1; EG1 prefix 1,0; suffix 0,1; sign 0 -> mvd=(+5,0); EPMode=1 on last 5 requests.
- dec_rdy held low for 10 cycles mid-prefix, then raised -> no request during stall; same result as the unstalled run.
- mvd_zero=1 at start -> no ctx_mvd_addr_vld; mvd_out=0 and done pulse 2 cycles after start. rst_n low during EG_SUF -> all outputs 0 next cycle; a following late ruiBin_vld is ignored.
- With QDEC_MVD_PREFIX_CHK_EN and MAX_PREFIX=16, 17 prefix 1-bins -> mvd_err_intr pulse, no mvd_done_intr, block back in IDLE.
